tof_i2c_arbiter: RTL and testbench
==================================

# tof_i2c_arbiter

Shares the single I2C master among `N_REQ` ToF sensor controllers: collects register-read/write requests, grants one at a time in round-robin order, drives the master's command/start interface, and returns completion, error and read data to the granted requester. It sits between the per-sensor ToF FSMs and the I2C master, and adds a watchdog so a hung bus cannot stall every sensor.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles a transaction may stay outstanding before abort.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low reset (asserted when 0, sampled on `clk`).
- `req`  in  N_REQ: per-requester request level.
- `req_addr`  in  N_REQ*16: flattened register addresses; slice i = requester i.
- `req_is_read`  in  N_REQ: 1 = read, 0 = write.
- `req_nb_of_bytes`  in  N_REQ*10: transfer length per requester.
- `req_wdata`  in  N_REQ*8: write byte per requester.
- `grant`  out  N_REQ: one-hot owner of the master, held for the whole transaction.
- `done`  out  N_REQ: one-cycle one-hot pulse, successful completion.
- `err`  out  N_REQ: one-cycle one-hot pulse, master error or timeout.
- `rdata`  out  16: read data of the last successful transaction, held until the next one.
- `busy`  out  1: a transaction is outstanding.
- `timeout_flag`  out  1: sticky, set by any watchdog abort, cleared only by reset.
- `register_address`  out  16, `is_read`  out  1, `nb_of_bytes`  out  10, `i2c_data`  out  8: command to the master.
- `start`  out  1: command valid, level-held.
- `ready`  in  1, `error_in`  in  1, `i2c_data_in`  in  16: master status/data.

## Operation
- States: IDLE, WAIT, GAP.
- IDLE: if any `req` bit set, winner w = first set bit at or after `rr_ptr`, searching circularly. Register w's command into the master outputs, set `grant[w]`, `start`=1, `busy`=1, clear watchdog, go to WAIT. No request: stay.
- WAIT: command outputs and `start` held stable. Watchdog increments each cycle.
  - `error_in`=1 (priority over `ready`): `err[w]` pulse.
  - else `ready`=1: `done[w]` pulse; if `is_read`, `rdata` <= `i2c_data_in`.
  - else watchdog == `TIMEOUT_CYCLES`-1: `err[w]` pulse, `timeout_flag`<=1.
  - On any of these: `start`<=0, `grant`<=0, `rr_ptr`<= (w+1) mod N_REQ, go to GAP.
- GAP: one cycle with `start`=0 (master rearm), `busy`<=0, then IDLE.
- Request fields are sampled only at grant; later changes have no effect. A `req` drop during WAIT does not abort; the completion pulse is still issued. Requesters deassert `req` in the cycle after `done`/`err`, or their request is re-arbitrated.
- Write transfers: `rdata` unchanged. Errors never update `rdata`.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, all outputs 0, `rr_ptr`=0, watchdog 0, `timeout_flag`=0. Reset mid-transaction drops `start` at that edge, with no `done`/`err` pulse.
- A request seen in IDLE at edge T gives `start`=1 and `grant` from T+1.
- `ready`/`error_in` seen at edge R gives `done`/`err` high in cycle R+1 and `start` low from R+1. IDLE is re-entered at R+2, and the next `start` is at R+3 at the earliest. Back-to-back throughput is 3 cycles plus master latency.
- `done`, `err` and `grant` are never high for more than one requester at a time. `done` and `err` are never both high.
- Watchdog abort: `err` high in exactly cycle T+1+`TIMEOUT_CYCLES`.

## Structure
- Package `tof_i2c_pkg`: state enum, `i2c_cmd_t` struct (addr 16, is_read, nb_of_bytes 10, wdata 8), width constants shared with the ToF FSMs and the I2C master.
- Sub-module `tof_rr_pick`: combinational circular priority pick (inputs `req`, `rr_ptr`; outputs `valid` and index). Reused by later arbiters.

## Test plan
- Single read: req[2], addr 0x0109, master `ready` 5 cycles after `start` with data 0x1234 -> `grant`=0100, `done`=0100 one cycle, `rdata`=0x1234, `busy` low two cycles later.
- All four requesting continuously: grant order 0,1,2,3,0 with `rr_ptr` wrapping, and one GAP cycle with `start`=0 between transactions.
- `ready` and `error_in` high in the same cycle -> `err[w]` only, `rdata` unchanged, `done` stays 0.
- Master silent with `TIMEOUT_CYCLES`=16 -> `err[w]` exactly 17 cycles after grant edge, `timeout_flag`=1 and stays set; the next request is served normally.
- Reset pulled low during WAIT -> `start`, `grant` and `busy` are 0 next cycle, no pulses; a fresh req[0] after release is granted first.
- req[1] changes `req_addr` during WAIT -> `register_address` keeps the value sampled at grant.

Source files
------------

// File: rtl/tof_i2c_pkg.sv
// Shared types and widths for the ToF sensor controllers, the I2C master
// and the arbiter that sits between them.
package tof_i2c_pkg;

    localparam int ADDR_W  = 16;  // I2C register address
    localparam int NB_W    = 10;  // transfer length field
    localparam int WDATA_W = 8;   // write byte
    localparam int RDATA_W = 16;  // read data returned by the master

    typedef enum logic [1:0] {
        ST_IDLE,  // arbitrate among pending requests
        ST_WAIT,  // command held, waiting for master or watchdog
        ST_GAP    // one cycle with start low so the master rearms
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               is_read;
        logic [NB_W-1:0]    nb_of_bytes;
        logic [WDATA_W-1:0] wdata;
    } i2c_cmd_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int safe_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tof_rr_pick.sv
// Combinational circular priority pick: the first set request bit at or
// after ptr, wrapping around. Reused by other round-robin arbiters.
module tof_rr_pick
    import tof_i2c_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = safe_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    // Scan N_REQ positions starting at rr_ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/tof_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among N_REQ ToF sensor
// controllers, with a watchdog that aborts a transaction the master never
// finishes so one hung bus cannot stall every sensor.
module tof_i2c_arbiter
    import tof_i2c_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ-1:0]           req_is_read,
    input  logic [N_REQ*NB_W-1:0]      req_nb_of_bytes,
    input  logic [N_REQ*WDATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           err,
    output logic [RDATA_W-1:0]         rdata,
    output logic                       busy,
    output logic                       timeout_flag,
    output logic [ADDR_W-1:0]          register_address,
    output logic                       is_read,
    output logic [NB_W-1:0]            nb_of_bytes,
    output logic [WDATA_W-1:0]         i2c_data,
    output logic                       start,
    input  logic                       ready,
    input  logic                       error_in,
    input  logic [RDATA_W-1:0]         i2c_data_in
);

    localparam int PTR_W = safe_width(N_REQ);
    localparam int WD_W  = safe_width(TIMEOUT_CYCLES);

    arb_state_t         state_q,   state_d;
    logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0]   owner_q,   owner_d;
    logic [WD_W-1:0]    wd_q,      wd_d;
    i2c_cmd_t           cmd_q,     cmd_d;
    logic               start_q,   start_d;
    logic               busy_q,    busy_d;
    logic               tflag_q,   tflag_d;
    logic [N_REQ-1:0]   grant_q,   grant_d;
    logic [N_REQ-1:0]   done_q,    done_d;
    logic [N_REQ-1:0]   err_q,     err_d;
    logic [RDATA_W-1:0] rdata_q,   rdata_d;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;

    tof_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // State register; synchronous active-low reset clears everything,
    // dropping start mid-transaction without any completion pulse.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every
        // register samples the pre-edge values, independent of order.
        if (!reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wd_q     <= '0;
            cmd_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            tflag_q  <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wd_q     <= wd_d;
            cmd_q    <= cmd_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            tflag_q  <= tflag_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, complete/abort in WAIT, rearm in GAP.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        wd_d     = wd_q;
        cmd_d    = cmd_q;
        start_d  = start_q;
        busy_d   = busy_q;
        tflag_d  = tflag_q;
        grant_d  = grant_q;
        rdata_d  = rdata_q;
        done_d   = '0;  // pulses last exactly one cycle
        err_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    // Request fields are captured here only; later changes
                    // on the requester side do not reach the master.
                    cmd_d.addr        = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    cmd_d.is_read     = req_is_read[pick_idx];
                    cmd_d.nb_of_bytes = req_nb_of_bytes[int'(pick_idx)*NB_W +: NB_W];
                    cmd_d.wdata       = req_wdata[int'(pick_idx)*WDATA_W +: WDATA_W];
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    start_d           = 1'b1;
                    busy_d            = 1'b1;
                    wd_d              = '0;
                    state_d           = ST_WAIT;
                end
            end

            ST_WAIT: begin
                logic finish;
                finish = 1'b1;
                wd_d   = wd_q + WD_W'(1);
                if (error_in) begin
                    err_d[owner_q] = 1'b1;
                end else if (ready) begin
                    done_d[owner_q] = 1'b1;
                    if (cmd_q.is_read) begin
                        rdata_d = i2c_data_in;
                    end
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d[owner_q] = 1'b1;
                    tflag_d        = 1'b1;
                end else begin
                    finish = 1'b0;
                end

                if (finish) begin
                    start_d  = 1'b0;
                    grant_d  = '0;
                    rr_ptr_d = (owner_q == PTR_W'(N_REQ - 1)) ? '0
                                                              : owner_q + PTR_W'(1);
                    state_d  = ST_GAP;
                end
            end

            ST_GAP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant            = grant_q;
    assign done             = done_q;
    assign err              = err_q;
    assign rdata            = rdata_q;
    assign busy             = busy_q;
    assign timeout_flag     = tflag_q;
    assign register_address = cmd_q.addr;
    assign is_read          = cmd_q.is_read;
    assign nb_of_bytes      = cmd_q.nb_of_bytes;
    assign i2c_data         = cmd_q.wdata;
    assign start            = start_q;

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// Directed bench for tof_i2c_arbiter: a scoreboard queue holds the expected
// done/err pulses, a negedge monitor compares them whenever a pulse appears.
module tb_tof_i2c_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*16-1:0] req_addr = '0;
    logic [N-1:0]  req_is_read = '0;
    logic [N*10-1:0] req_nb_of_bytes = '0;
    logic [N*8-1:0]  req_wdata = '0;
    logic [N-1:0]  grant, done, err;
    logic [15:0]   rdata;
    logic          busy, timeout_flag;
    logic [15:0]   register_address;
    logic          is_read;
    logic [9:0]    nb_of_bytes;
    logic [7:0]    i2c_data;
    logic          start;
    logic          ready = 1'b0;
    logic          error_in = 1'b0;
    logic [15:0]   i2c_data_in = '0;

    tof_i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_addr         (req_addr),
        .req_is_read      (req_is_read),
        .req_nb_of_bytes  (req_nb_of_bytes),
        .req_wdata        (req_wdata),
        .grant            (grant),
        .done             (done),
        .err              (err),
        .rdata            (rdata),
        .busy             (busy),
        .timeout_flag     (timeout_flag),
        .register_address (register_address),
        .is_read          (is_read),
        .nb_of_bytes      (nb_of_bytes),
        .i2c_data         (i2c_data),
        .start            (start),
        .ready            (ready),
        .error_in         (error_in),
        .i2c_data_in      (i2c_data_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [N-1:0] done;
        logic [N-1:0] err;
        logic [15:0]  rdata;
        logic         tflag;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req_v);
        end
    endtask

    task automatic expect_pulse(input logic [N-1:0] d, input logic [N-1:0] e,
                                input logic [15:0] rd, input logic tf);
        exp_t x;
        x.done = d; x.err = e; x.rdata = rd; x.tflag = tf;
        exp_q.push_back(x);
    endtask

    // Monitor: every done/err pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset && (done != '0 || err != '0)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: done=%b err=%b, required none", done, err);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("pulse_done",  32'(done),  32'(x.done));
                check("pulse_err",   32'(err),   32'(x.err));
                check("pulse_rdata", 32'(rdata), 32'(x.rdata));
                check("pulse_tflag", 32'(timeout_flag), 32'(x.tflag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input logic [15:0] a, input logic rd,
                              input logic [9:0] nb, input logic [7:0] wd);
        req_addr[i*16 +: 16]       = a;
        req_is_read[i]             = rd;
        req_nb_of_bytes[i*10 +: 10] = nb;
        req_wdata[i*8 +: 8]        = wd;
    endtask

    // Bounded wait for start; an expired bound is a failed comparison.
    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (start !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        n_checks++;
        if (start !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_start: start=%b after %0d cycles, required 1", name, start, k);
        end
    endtask

    // Master response lat cycles after start was first seen.
    task automatic respond(input int lat, input bit rdy, input bit er, input logic [15:0] d);
        repeat (lat) tick();
        ready = rdy; error_in = er; i2c_data_in = d;
        tick();
        ready = 1'b0; error_in = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_start", 32'(start), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_tflag", 32'(timeout_flag), 0);
        check("rst_addr",  32'(register_address), 0);
        reset = 1'b1;
        tick();

        // Single read from requester 2
        set_fields(2, 16'h0109, 1'b1, 10'd2, 8'h00);
        req = 4'b0100;
        wait_start("single");
        check("single_grant", 32'(grant), 32'b0100);
        check("single_addr",  32'(register_address), 32'h0109);
        check("single_isrd",  32'(is_read), 1);
        check("single_nb",    32'(nb_of_bytes), 2);
        check("single_busy",  32'(busy), 1);
        expect_pulse(4'b0100, 4'b0000, 16'h1234, 1'b0);
        respond(5, 1'b1, 1'b0, 16'h1234);
        req = '0;
        check("single_start_low", 32'(start), 0);
        check("single_grant_low", 32'(grant), 0);
        check("single_busy_gap",  32'(busy), 1);
        tick();
        check("single_busy_low",  32'(busy), 0);
        check("single_rdata",     32'(rdata), 32'h1234);

        // Reset so rr_ptr restarts at 0, then all four request continuously
        reset = 1'b0; tick(); reset = 1'b1; tick();
        for (int i = 0; i < N; i++)
            set_fields(i, 16'h0100 + 16'(i), (i != 1), 10'(i + 1), 8'(8'h50 + i));
        req = 4'b1111;
        begin
            logic [15:0] exp_rd;
            exp_rd = 16'h0000;
            for (int k = 0; k < 5; k++) begin
                int w;
                w = k % N;
                wait_start($sformatf("rr%0d", k));
                check($sformatf("rr%0d_grant", k), 32'(grant), 32'(1 << w));
                check($sformatf("rr%0d_addr", k), 32'(register_address), 32'(16'h0100 + w));
                check($sformatf("rr%0d_wdata", k), 32'(i2c_data), 32'(8'h50 + w));
                if (w != 1) exp_rd = 16'hA000 + 16'(k);
                expect_pulse(4'(1 << w), 4'b0000, exp_rd, 1'b0);
                respond(1 + k, 1'b1, 1'b0, 16'hA000 + 16'(k));
                if (k == 4) req = '0;
                check($sformatf("rr%0d_gap_a", k), 32'(start), 0);
                tick();
                check($sformatf("rr%0d_gap_b", k), 32'(start), 0);
            end
        end
        check("rr_rdata", 32'(rdata), 32'hA004);

        // ready and error_in together: err wins, rdata unchanged
        tick();
        set_fields(3, 16'h0303, 1'b1, 10'd1, 8'h00);
        req = 4'b1000;
        wait_start("both");
        check("both_grant", 32'(grant), 32'b1000);
        expect_pulse(4'b0000, 4'b1000, 16'hA004, 1'b0);
        respond(2, 1'b1, 1'b1, 16'hDEAD);
        req = '0;
        check("both_done", 32'(done), 0);
        tick(); tick();

        // Silent master: watchdog abort 17 cycles after the grant edge
        set_fields(1, 16'h0111, 1'b1, 10'd1, 8'h00);
        req = 4'b0010;
        wait_start("wd");
        check("wd_grant", 32'(grant), 32'b0010);
        expect_pulse(4'b0000, 4'b0010, 16'hA004, 1'b1);
        repeat (TO - 1) tick();
        check("wd_err_early", 32'(err), 0);
        check("wd_tflag_early", 32'(timeout_flag), 0);
        tick();
        check("wd_err_on_time", 32'(err), 32'b0010);
        req = '0;
        repeat (4) tick();
        check("wd_tflag_sticky", 32'(timeout_flag), 1);
        set_fields(2, 16'h0222, 1'b0, 10'd1, 8'h77);
        req = 4'b0100;
        wait_start("post_wd");
        check("post_wd_grant", 32'(grant), 32'b0100);
        expect_pulse(4'b0100, 4'b0000, 16'hA004, 1'b1);
        respond(2, 1'b1, 1'b0, 16'hBEEF);
        req = '0;
        tick(); tick();

        // Reset during WAIT: everything drops, no pulse; req[0] wins after
        set_fields(3, 16'h0333, 1'b1, 10'd1, 8'h00);
        req = 4'b1000;
        wait_start("rstw");
        check("rstw_grant", 32'(grant), 32'b1000);
        tick();
        reset = 1'b0;
        tick();
        check("rstw_start", 32'(start), 0);
        check("rstw_grant0", 32'(grant), 0);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_pulses", 32'({done, err}), 0);
        check("rstw_tflag", 32'(timeout_flag), 0);
        reset = 1'b1;
        set_fields(0, 16'h0000, 1'b1, 10'd1, 8'h00);
        req = 4'b1001;
        wait_start("fresh");
        check("fresh_grant", 32'(grant), 32'b0001);
        expect_pulse(4'b0001, 4'b0000, 16'h5555, 1'b0);
        respond(1, 1'b1, 1'b0, 16'h5555);
        req = '0;
        tick(); tick();

        // Field change during WAIT does not reach the master
        set_fields(1, 16'h0AAA, 1'b0, 10'd3, 8'h11);
        req = 4'b0010;
        wait_start("hold");
        check("hold_grant", 32'(grant), 32'b0010);
        set_fields(1, 16'h0BBB, 1'b1, 10'd9, 8'h22);
        repeat (2) tick();
        check("hold_addr",  32'(register_address), 32'h0AAA);
        check("hold_isrd",  32'(is_read), 0);
        check("hold_wdata", 32'(i2c_data), 32'h11);
        expect_pulse(4'b0010, 4'b0000, 16'h5555, 1'b0);
        respond(1, 1'b1, 1'b0, 16'h9999);
        req = '0;
        repeat (3) tick();

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

endmodule
